vebpf_req_arbiter: RTL and testbench

Round-robin front end that shares one `vebpf_scheduler` call port (`vebpf_core_req`/`vebpf_request`/`vebpf_r1..r3` → `vebpf_r0`/`vebpf_r0_valid`) among `NUM_REQ` independent requesters. It accepts one call at a time, issues it to the scheduler as a single-cycle request pulse, waits for completion or timeout, and routes the 64-bit result back to the originating requester. It sits between the host/packet-side clients and the scheduler, so the scheduler always sees exactly one outstanding call.

---
 rtl/vebpf_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vebpf_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vebpf_req_arbiter.sv
// rtl/vebpf_req_arbiter.sv - round-robin front end sharing one vebpf_scheduler call port
// Accepts one call at a time, pulses it to the scheduler and routes the result back.
module vebpf_req_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int FUNCTION_ID_WIDTH = 8,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*FUNCTION_ID_WIDTH-1:0] req_fid,
    input  logic [NUM_REQ*64-1:0]                req_r1,
    input  logic [NUM_REQ*64-1:0]                req_r2,
    input  logic [NUM_REQ*64-1:0]                req_r3,
    output logic [NUM_REQ-1:0]                   resp_valid,
    output logic [63:0]                          resp_r0,
    output logic                                 resp_timeout,
    output logic [FUNCTION_ID_WIDTH-1:0]         sch_core_req,
    output logic                                 sch_request,
    output logic [63:0]                          sch_r1,
    output logic [63:0]                          sch_r2,
    output logic [63:0]                          sch_r3,
    input  logic [63:0]                          sch_r0,
    input  logic                                 sch_r0_valid,
    output logic                                 busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int FW    = FUNCTION_ID_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [FW-1:0]        fid_q, fid_d;
    logic [63:0]          r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [63:0]          r0_q, r0_d;
    logic                 timeout_q, timeout_d;
    logic                 prev_q;
    logic [31:0]          wait_cnt_q, wait_cnt_d;

    logic                 gnt_found;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     cand;
    logic                 sch_edge;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // A level still high from an earlier call must not count as completion.
    assign sch_edge = sch_r0_valid && !prev_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        g_d        = g_q;
        fid_d      = fid_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        r3_d       = r3_q;
        r0_d       = r0_q;
        timeout_d  = timeout_q;
        wait_cnt_d = wait_cnt_q;
        req_ready  = '0;
        resp_valid = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!rst && gnt_found) begin
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
                end
                if (gnt_found) begin
                    g_d     = gnt_idx;
                    fid_d   = req_fid[int'(gnt_idx)*FW +: FW];
                    r1_d    = req_r1[int'(gnt_idx)*64 +: 64];
                    r2_d    = req_r2[int'(gnt_idx)*64 +: 64];
                    r3_d    = req_r3[int'(gnt_idx)*64 +: 64];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (sch_edge) begin
                    r0_d      = sch_r0;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    r0_d      = '1;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << g_q;
                rr_ptr_d   = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            g_q        <= '0;
            fid_q      <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            r0_q       <= '0;
            timeout_q  <= 1'b0;
            prev_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            g_q        <= g_d;
            fid_q      <= fid_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            r0_q       <= r0_d;
            timeout_q  <= timeout_d;
            prev_q     <= sch_r0_valid;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign sch_request  = (state_q == S_ISSUE);
    assign sch_core_req = fid_q;
    assign sch_r1       = r1_q;
    assign sch_r2       = r2_q;
    assign sch_r3       = r3_q;
    assign resp_r0      = r0_q;
    assign resp_timeout = (state_q == S_RESP) && timeout_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vebpf_req_arbiter.sv
// tb/tb_vebpf_req_arbiter.sv - directed bench for vebpf_req_arbiter with a cycle-stamp model
module tb_vebpf_req_arbiter;

    localparam int NR = 4;
    localparam int FW = 8;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*FW-1:0]  req_fid = '0;
    logic [NR*64-1:0]  req_r1 = '0, req_r2 = '0, req_r3 = '0;
    logic [NR-1:0]     resp_valid;
    logic [63:0]       resp_r0;
    logic              resp_timeout;
    logic [FW-1:0]     sch_core_req;
    logic              sch_request;
    logic [63:0]       sch_r1, sch_r2, sch_r3;
    logic [63:0]       sch_r0 = '0;
    logic              sch_r0_valid = 1'b0;
    logic              busy;

    vebpf_req_arbiter #(
        .NUM_REQ(NR), .FUNCTION_ID_WIDTH(FW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fid(req_fid),
        .req_r1(req_r1), .req_r2(req_r2), .req_r3(req_r3),
        .resp_valid(resp_valid), .resp_r0(resp_r0), .resp_timeout(resp_timeout),
        .sch_core_req(sch_core_req), .sch_request(sch_request),
        .sch_r1(sch_r1), .sch_r2(sch_r2), .sch_r3(sch_r3),
        .sch_r0(sch_r0), .sch_r0_valid(sch_r0_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tcyc = 0;
    int order_q[$];
    logic [FW-1:0] cap_fid;
    logic [63:0]   cap_r1, cap_r2, cap_r3;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: calls tracked by the cycle they were granted and resolved.
    bit          m_busy = 0, m_to = 0, m_prev = 0;
    int          m_gcyc = 0, m_rcyc = -1, m_g = 0, m_rr = 0, mt = 0, p = -1;
    logic [FW-1:0] m_fid = '0;
    logic [63:0] m_r1 = '0, m_r2 = '0, m_r3 = '0, m_r0 = '0;
    logic [NR-1:0] e_ready, e_resp;
    bit          e_req, e_to, e_busy;

    function automatic int pick(input logic [NR-1:0] v, input int rr);
        for (int i = 0; i < NR; i++) begin
            if (v[(rr + i) % NR]) return (rr + i) % NR;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        e_ready = '0; e_resp = '0; e_req = 0; e_to = 0; e_busy = 0; p = -1;
        if (rst) begin
            m_busy = 0; m_rr = 0; m_prev = 0; m_to = 0; m_rcyc = -1;
            m_fid = '0; m_r1 = '0; m_r2 = '0; m_r3 = '0; m_r0 = '0;
        end else begin
            e_busy = m_busy;
            if (!m_busy) begin
                p = pick(req_valid, m_rr);
                if (p >= 0) e_ready[p] = 1'b1;
            end else begin
                e_req = (mt == m_gcyc + 1);
                if (mt == m_rcyc) begin
                    e_resp[m_g] = 1'b1;
                    e_to = m_to;
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("sch_request", 64'(sch_request), 64'(e_req));
        chk("resp_valid", 64'(resp_valid), 64'(e_resp));
        chk("resp_timeout", 64'(resp_timeout), 64'(e_to));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("resp_r0", resp_r0, m_r0);
        chk("sch_core_req", 64'(sch_core_req), 64'(m_fid));
        chk("sch_r1", sch_r1, m_r1);
        chk("sch_r2", sch_r2, m_r2);
        chk("sch_r3", sch_r3, m_r3);
        if (!rst) begin
            if (!m_busy) begin
                if (p >= 0) begin
                    m_busy = 1; m_gcyc = mt; m_rcyc = -1; m_g = p;
                    m_fid = req_fid[p*FW +: FW];
                    m_r1 = req_r1[p*64 +: 64];
                    m_r2 = req_r2[p*64 +: 64];
                    m_r3 = req_r3[p*64 +: 64];
                end
            end else if (mt == m_rcyc) begin
                m_busy = 0;
                m_rr = (m_g + 1) % NR;
            end else if (m_rcyc < 0 && mt >= m_gcyc + 2) begin
                if (sch_r0_valid && !m_prev) begin
                    m_r0 = sch_r0; m_to = 0; m_rcyc = mt + 1;
                end else if (mt - (m_gcyc + 2) == TO - 1) begin
                    m_r0 = '1; m_to = 1; m_rcyc = mt + 1;
                end
            end
            m_prev = sch_r0_valid;
        end
        mt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (sch_request) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("issue_wait_bound", 64'(sch_request), 64'd1);
        cap_fid = sch_core_req; cap_r1 = sch_r1; cap_r2 = sch_r2; cap_r3 = sch_r3;
    endtask

    // Scheduler stand-in: rises `delay` cycles after the issue cycle (never if delay<0),
    // optionally forcing the level low at issue+low_at first.
    task automatic run_call(input int delay, input logic [63:0] r0v, input logic [NR-1:0] clr,
                            input bit drop, input int low_at,
                            output logic [NR-1:0] rv, output logic [63:0] rr0,
                            output logic rto, output int lat);
        bit ok;
        int i0;
        int n;
        wait_req(ok);
        order_q.push_back(int'(sch_core_req));
        i0 = tcyc;
        req_valid = req_valid & ~clr;
        for (int c = 1; c <= delay; c++) begin
            tick();
            if (c == low_at) sch_r0_valid = 1'b0;
        end
        if (delay > 0) begin
            sch_r0 = r0v;
            sch_r0_valid = 1'b1;
        end
        n = 0;
        while (resp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        if (resp_valid == '0) chk("resp_wait_bound", 64'(resp_valid), 64'd1);
        rv = resp_valid; rr0 = resp_r0; rto = resp_timeout; lat = tcyc - i0;
        if (drop) sch_r0_valid = 1'b0;
    endtask

    logic [NR-1:0] rv;
    logic [63:0]   rr0;
    logic          rto;
    int            lat;
    int            exp_order[8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h13, 8'h11};

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_r0", resp_r0, 64'd0);
        chk("rst_sch_core_req", 64'(sch_core_req), 64'd0);
        rst = 1'b0;
        tick();

        // Fairness: all four valid, then only 1 and 3 with rr_ptr at 2.
        for (int k = 0; k < NR; k++) begin
            req_fid[k*FW +: FW] = 8'(8'h10 + k);
            req_r1[k*64 +: 64]  = 64'(k + 1);
            req_r2[k*64 +: 64]  = 64'(k * 16);
            req_r3[k*64 +: 64]  = 64'h0000_C0DE_0000_0000 + 64'(k);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            run_call(3, 64'h100 + 64'(i), 4'b0000, 1'b1, 0, rv, rr0, rto, lat);
            chk("fair_lat", 64'(lat), 64'd4);
            chk("fair_r0", rr0, 64'h100 + 64'(i));
        end
        req_valid = 4'b1010;
        run_call(3, 64'h200, 4'b1000, 1'b1, 0, rv, rr0, rto, lat);
        chk("fair_rv3", 64'(rv), 64'b1000);
        run_call(3, 64'h201, 4'b0010, 1'b1, 0, rv, rr0, rto, lat);
        chk("fair_rv1", 64'(rv), 64'b0010);
        chk("fair_order_len", 64'(order_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < order_q.size(); i++) chk("fair_order", 64'(order_q[i]), 64'(exp_order[i]));

        // Single call from requester 0.
        req_fid[0 +: FW] = 8'h01;
        req_r1[0 +: 64] = 64'd4;
        req_r2[0 +: 64] = 64'h2222;
        req_r3[0 +: 64] = 64'h3333;
        req_valid = 4'b0001;
        run_call(20, 64'h10, 4'b0001, 1'b1, 0, rv, rr0, rto, lat);
        chk("single_fid", 64'(cap_fid), 64'h01);
        chk("single_r1", cap_r1, 64'd4);
        chk("single_r2", cap_r2, 64'h2222);
        chk("single_r3", cap_r3, 64'h3333);
        chk("single_rv", 64'(rv), 64'b0001);
        chk("single_r0", rr0, 64'h10);
        chk("single_to", 64'(rto), 64'd0);
        chk("single_lat", 64'(lat), 64'd21);

        // Timeout from requester 2, then a normal call from requester 1.
        req_valid = 4'b0100;
        run_call(-1, 64'h0, 4'b0100, 1'b1, 0, rv, rr0, rto, lat);
        chk("to_rv", 64'(rv), 64'b0100);
        chk("to_r0", rr0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("to_flag", 64'(rto), 64'd1);
        chk("to_lat", 64'(lat), 64'd65);
        req_valid = 4'b0010;
        run_call(5, 64'h77, 4'b0010, 1'b1, 0, rv, rr0, rto, lat);
        chk("after_to_rv", 64'(rv), 64'b0010);
        chk("after_to_r0", rr0, 64'h77);
        chk("after_to_flag", 64'(rto), 64'd0);
        chk("after_to_lat", 64'(lat), 64'd6);

        // Held level: result valid stays high into the next call's WAIT.
        req_valid = 4'b0001;
        run_call(2, 64'hAA, 4'b0001, 1'b0, 0, rv, rr0, rto, lat);
        chk("held_a_lat", 64'(lat), 64'd3);
        req_valid = 4'b0010;
        run_call(12, 64'hBB, 4'b0010, 1'b1, 10, rv, rr0, rto, lat);
        chk("held_b_rv", 64'(rv), 64'b0010);
        chk("held_b_r0", rr0, 64'hBB);
        chk("held_b_lat", 64'(lat), 64'd13);

        // Edge on the terminal-count cycle: completion wins.
        req_valid = 4'b0001;
        run_call(TO, 64'h55, 4'b0001, 1'b1, 0, rv, rr0, rto, lat);
        chk("tie_r0", rr0, 64'h55);
        chk("tie_to", 64'(rto), 64'd0);
        chk("tie_lat", 64'(lat), 64'd65);

        // Reset mid-WAIT; the scheduler later finishes the dropped call.
        req_valid = 4'b0100;
        begin
            bit ok;
            wait_req(ok);
        end
        req_valid = 4'b0000;
        repeat (5) tick();
        req_valid = 4'b1001;
        rst = 1'b1;
        #1;
        chk("rst_now_busy", 64'(busy), 64'd0);
        chk("rst_now_ready", 64'(req_ready), 64'd0);
        chk("rst_now_r0", resp_r0, 64'd0);
        chk("rst_now_r1", sch_r1, 64'd0);
        chk("rst_now_req", 64'(sch_request), 64'd0);
        chk("rst_now_resp", 64'(resp_valid), 64'd0);
        sch_r0 = 64'hDEAD;
        sch_r0_valid = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b0001);
        run_call(4, 64'h42, 4'b0001, 1'b1, 2, rv, rr0, rto, lat);
        chk("post_rst_rv", 64'(rv), 64'b0001);
        chk("post_rst_r0", rr0, 64'h42);
        chk("post_rst_lat", 64'(lat), 64'd5);
        run_call(3, 64'h33, 4'b1000, 1'b1, 0, rv, rr0, rto, lat);
        chk("post_rst_rv3", 64'(rv), 64'b1000);
        chk("post_rst_r0_3", rr0, 64'h33);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
